// File: rtl/bitsync_lock_ctrl.sv
// Purpose : lock/phase controller for the bit-sync datapath; classifies data edges
//           against the recovered sync clock, issues DPLL advance/retard commands and
//           runs the IDLE/ACQUIRE/LOCKED state machine.
// Latency : inputs pass a 3-flop synchroniser; outputs are registered and appear three
//           clk_i edges after an input transition (two sync stages, one output stage).
// Backpressure: none; the DPLL must accept every single-cycle adv/ret pulse.
//
// Ports
//   clk_i        system clock (200 MHz PLL domain)
//   rst_n_i      asynchronous active-low reset
//   en_i         controller enable; low forces IDLE and suppresses pulses
//   sig_in_i     asynchronous data stream (Manchester or M-sequence)
//   sync_clk_i   asynchronous recovered bit clock from the DPLL
//   adv_pulse_o  one-cycle request to advance DPLL phase (data edge arrived early)
//   ret_pulse_o  one-cycle request to retard DPLL phase (data edge arrived late)
//   locked_o     high while in LOCKED
//   lost_lock_o  one-cycle pulse on the LOCKED -> ACQUIRE transition
//   state_o      00 IDLE, 01 ACQUIRE, 10 LOCKED
module bitsync_lock_ctrl #(
   parameter int CNT_W    = 8,
   parameter int HALF_PER = 100,
   parameter int DEADBAND = 4,
   parameter int LOCK_N   = 16,
   parameter int UNLOCK_N = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       en_i,
   input  logic       sig_in_i,
   input  logic       sync_clk_i,
   output logic       adv_pulse_o,
   output logic       ret_pulse_o,
   output logic       locked_o,
   output logic       lost_lock_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACQ    = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] WIN_LO     = CNT_W'(DEADBAND);
   localparam logic [CNT_W-1:0] WIN_HI     = CNT_W'(2*HALF_PER - DEADBAND);
   localparam logic [CNT_W-1:0] HALF       = CNT_W'(HALF_PER);
   localparam logic [CNT_W-1:0] LOCK_THR   = CNT_W'(LOCK_N);
   localparam logic [CNT_W-1:0] UNLOCK_THR = CNT_W'(UNLOCK_N);
   localparam logic [CNT_W-1:0] TMO_THR    = CNT_W'(TIMEOUT);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Synchronisers: bit 0 = stage 1, bit 1 = stage 2, bit 2 = stage 3.
   logic [2:0] sig_sync_q, clk_sync_q;

   logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
   logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
   logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   state_t           state_q, state_d;
   logic             corr_done_q, corr_done_d;
   logic             adv_q, adv_d;
   logic             ret_q, ret_d;
   logic             lost_q, lost_d;

   logic             data_edge, clk_rise;
   logic             in_win, is_late, active, corr_req;
   logic [CNT_W-1:0] good_inc, bad_inc;

   assign data_edge = sig_sync_q[1] ^ sig_sync_q[2];
   assign clk_rise  = clk_sync_q[1] & ~clk_sync_q[2];

   // phase_cnt still holds last period's count in the clk_rise cycle, so a
   // coincident data edge is forced in-window (phase treated as 0).
   assign in_win  = clk_rise | (phase_cnt_q <= WIN_LO) | (phase_cnt_q >= WIN_HI);
   assign is_late = (phase_cnt_q < HALF);
   assign active  = en_i & (state_q != ST_IDLE);
   // At most one correction per sync_clk period; later bad edges still count.
   assign corr_req = data_edge & ~in_win & active & ~corr_done_q;

   assign good_inc = sat_inc(good_cnt_q);
   assign bad_inc  = sat_inc(bad_cnt_q);

   assign phase_cnt_d = clk_rise ? '0 : sat_inc(phase_cnt_q);

   always_comb begin
      state_d     = state_q;
      good_cnt_d  = good_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      lost_d      = 1'b0;
      adv_d       = corr_req & ~is_late;
      ret_d       = corr_req & is_late;
      corr_done_d = clk_rise ? 1'b0 : (corr_done_q | corr_req);

      if (data_edge) begin
         idle_cnt_d = '0;
      end else if (clk_rise) begin
         idle_cnt_d = sat_inc(idle_cnt_q);
      end

      unique case (state_q)
         ST_IDLE: begin
            good_cnt_d  = '0;
            bad_cnt_d   = '0;
            idle_cnt_d  = '0;
            corr_done_d = 1'b0;
            if (en_i) begin
               state_d = ST_ACQ;
            end
         end
         ST_ACQ: begin
            if (data_edge) begin
               if (in_win) begin
                  good_cnt_d = good_inc;
                  if (good_inc >= LOCK_THR) begin
                     state_d   = ST_LOCKED;
                     bad_cnt_d = '0;
                  end
               end else begin
                  good_cnt_d = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (data_edge) begin
               bad_cnt_d = in_win ? '0 : bad_inc;
            end
            if ((bad_cnt_d >= UNLOCK_THR) || (idle_cnt_d >= TMO_THR)) begin
               state_d    = ST_ACQ;
               lost_d     = 1'b1;
               good_cnt_d = '0;
               bad_cnt_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disable overrides everything, including a coincident loss of lock.
      if (!en_i) begin
         state_d = ST_IDLE;
         lost_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sig_sync_q  <= '0;
         clk_sync_q  <= '0;
         phase_cnt_q <= '0;
         good_cnt_q  <= '0;
         bad_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         state_q     <= ST_IDLE;
         corr_done_q <= 1'b0;
         adv_q       <= 1'b0;
         ret_q       <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         sig_sync_q  <= {sig_sync_q[1:0], sig_in_i};
         clk_sync_q  <= {clk_sync_q[1:0], sync_clk_i};
         phase_cnt_q <= phase_cnt_d;
         good_cnt_q  <= good_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         state_q     <= state_d;
         corr_done_q <= corr_done_d;
         adv_q       <= adv_d;
         ret_q       <= ret_d;
         lost_q      <= lost_d;
      end
   end

   assign adv_pulse_o = adv_q;
   assign ret_pulse_o = ret_q;
   assign lost_lock_o = lost_q;
   assign locked_o    = (state_q == ST_LOCKED);
   assign state_o     = state_q;

endmodule

// File: tb/tb_bitsync_lock_ctrl.sv
// Bench for bitsync_lock_ctrl: directed sync_clk periods with data edges placed at
// chosen phases; expected output transitions are queued as they are issued and a
// negedge monitor compares every observed output change against the queue head.
module tb_bitsync_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       sig_in = 1'b0;
   logic       sync_clk = 1'b0;
   logic       adv, ret, locked, lost;
   logic [1:0] state;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic       adv;
      logic       ret;
      logic       lost;
      logic       lk;
      logic [1:0] st;
      int         due;   // -1: any cycle
   } ev_t;

   ev_t exp_q[$];
   logic       exp_lk = 1'b0;
   logic [1:0] exp_st = 2'b00;

   localparam int K_NONE    = 0;
   localparam int K_ADV     = 1;
   localparam int K_RET     = 2;
   localparam int K_LOCK    = 3;
   localparam int K_ADVLOST = 4;

   bitsync_lock_ctrl dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .sig_in_i    (sig_in),
      .sync_clk_i  (sync_clk),
      .adv_pulse_o (adv),
      .ret_pulse_o (ret),
      .locked_o    (locked),
      .lost_lock_o (lost),
      .state_o     (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   wire [5:0] obs = {adv, ret, lost, locked, state};
   logic [5:0] mon_prev;

   // Monitor: any change of the output tuple is one DUT response.
   always @(negedge clk) begin
      if (mon_en && (obs !== mon_prev)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got adv=%b ret=%b lost=%b locked=%b state=%b at cyc %0d, required no change",
                     adv, ret, lost, locked, state, cyc);
         end else begin
            if (({exp_q[0].adv, exp_q[0].ret, exp_q[0].lost, exp_q[0].lk, exp_q[0].st} !== obs) ||
                (exp_q[0].due >= 0 && exp_q[0].due != cyc)) begin
               errors++;
               $display("FAIL event: got adv=%b ret=%b lost=%b locked=%b state=%b at cyc %0d, required adv=%b ret=%b lost=%b locked=%b state=%b at cyc %0d",
                        adv, ret, lost, locked, state, cyc,
                        exp_q[0].adv, exp_q[0].ret, exp_q[0].lost, exp_q[0].lk, exp_q[0].st, exp_q[0].due);
            end
            void'(exp_q.pop_front());
         end
      end
      mon_prev <= obs;
   end

   task automatic push(input logic a, input logic r, input logic l, input logic lk,
                       input logic [1:0] st, input int due);
      ev_t e;
      e.adv = a; e.ret = r; e.lost = l; e.lk = lk; e.st = st; e.due = due;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_adv"}, int'(adv), 0);
      chk({tag, "_ret"}, int'(ret), 0);
      chk({tag, "_lost"}, int'(lost), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_state"}, int'(state), 0);
   endtask

   // A sig_in toggle driven in cycle t surfaces at the outputs at cycle t+3.
   task automatic expect_edge(input int kind, input int t);
      case (kind)
         K_ADV: begin
            push(1'b1, 1'b0, 1'b0, exp_lk, exp_st, t + 3);
            push(1'b0, 1'b0, 1'b0, exp_lk, exp_st, t + 4);
         end
         K_RET: begin
            push(1'b0, 1'b1, 1'b0, exp_lk, exp_st, t + 3);
            push(1'b0, 1'b0, 1'b0, exp_lk, exp_st, t + 4);
         end
         K_LOCK: begin
            exp_lk = 1'b1; exp_st = 2'b10;
            push(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, t + 3);
         end
         K_ADVLOST: begin
            exp_lk = 1'b0; exp_st = 2'b01;
            push(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, t + 3);
            push(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, t + 4);
         end
         default: ;
      endcase
   endtask

   // One 200-cycle sync_clk period; sig_in toggles at offsets o1/o2 (-1 = none).
   // Offset 0 coincides with the rising edge (phase 0); offset k>0 gives phase k-1.
   task automatic do_period(input int o1, input int k1, input int o2, input int k2);
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         if (c == 0)   sync_clk = 1'b1;
         if (c == 100) sync_clk = 1'b0;
         if (c == o1) begin
            sig_in = ~sig_in;
            expect_edge(k1, cyc);
         end
         if (c == o2) begin
            sig_in = ~sig_in;
            expect_edge(k2, cyc);
         end
      end
   endtask

   // 16 in-window edges cycling through phase 0, phase 4 and phase 196.
   task automatic lock_seq();
      for (int i = 0; i < 16; i++) begin
         int off;
         off = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 5 : 197);
         do_period(off, (i == 15) ? K_LOCK : K_NONE, -1, K_NONE);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Enable: IDLE -> ACQUIRE next cycle.
      en = 1'b1;
      push(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, cyc + 1);
      exp_lk = 1'b0; exp_st = 2'b01;

      // Early edges (phase 150) in ACQUIRE: one advance per period.
      repeat (3) do_period(151, K_ADV, -1, K_NONE);
      // Late edges (phase 30, then 60 in same period): one retard per period.
      repeat (2) do_period(31, K_RET, 61, K_NONE);
      // Just outside the window on both sides: phase 5 late, phase 195 early.
      do_period(6, K_RET, -1, K_NONE);
      do_period(196, K_ADV, -1, K_NONE);

      // Acquire lock with in-window edges including both window edges.
      lock_seq();

      // Four early edges at phase 100 in LOCKED: 4 advances, loss on the 4th.
      repeat (3) do_period(101, K_ADV, -1, K_NONE);
      do_period(101, K_ADVLOST, -1, K_NONE);

      // Relock; 3 bad, 1 good, 3 bad stays LOCKED.
      lock_seq();
      repeat (3) do_period(101, K_ADV, -1, K_NONE);
      do_period(0, K_NONE, -1, K_NONE);
      repeat (3) do_period(101, K_ADV, -1, K_NONE);

      // Static data for 64+ periods: timeout drops lock.
      push(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, -1);
      push(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, -1);
      exp_lk = 1'b0; exp_st = 2'b01;
      repeat (66) do_period(-1, K_NONE, -1, K_NONE);

      // Disable from LOCKED: IDLE next cycle, no lost_lock.
      lock_seq();
      @(posedge clk);
      #1;
      en = 1'b0;
      push(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, cyc + 1);
      repeat (10) @(posedge clk);
      #1;
      en = 1'b1;
      push(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, cyc + 1);
      exp_lk = 1'b0; exp_st = 2'b01;
      lock_seq();

      // Asynchronous reset mid-lock: outputs clear immediately.
      push(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      en = 1'b1;
      push(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, cyc + 1);
      exp_lk = 1'b0; exp_st = 2'b01;
      // Lock must not return before the 16th in-window edge.
      lock_seq();

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_pending_events", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
